pcie_rx_ram_writer: RTL and testbench

Upstream stage of the PCIe host-to-FPGA receive path. Accepts framed 32-bit dwords from the PCIe RX interface, validates each packet against its header length, and writes it into the shared 2048 x 32 ring-buffer RAM. Only complete, well-formed packets become visible to the downstream read module, which drains the RAM using its own read address. Malformed or overflowing packets are rolled back and counted.

---
 rtl/pcie_buf_pkg.sv | 16 +
 rtl/pcie_rx_ram_writer.sv | 162 ++++++++++++++++
 tb/tb_pcie_rx_ram_writer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_buf_pkg.sv
// Shared definitions for the PCIe receive ring buffer (writer and downstream reader).
package pcie_buf_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned LEN_MSB = 9;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StDrop
    } rx_state_e;

endpackage

// File: rtl/pcie_rx_ram_writer.sv
// Validates framed PCIe RX packets and writes them into the shared ring RAM; only complete
// packets are published through commit_ptr, bad ones are rolled back and counted.
module pcie_rx_ram_writer #(
    parameter int unsigned ADDR_W  = pcie_buf_pkg::ADDR_W,
    parameter int unsigned DATA_W  = pcie_buf_pkg::DATA_W,
    parameter int unsigned MAX_LEN = pcie_buf_pkg::MAX_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              RAM_wr_en,
    output logic [ADDR_W-1:0] RAM_wr_addr,
    output logic [DATA_W-1:0] RAM_wr_data,
    output logic [ADDR_W-1:0] commit_ptr,
    output logic              pkt_avail,
    output logic [15:0]       drop_cnt
);
    import pcie_buf_pkg::*;

    localparam int unsigned LEN_W = LEN_MSB - LEN_LSB + 1;

    rx_state_e         state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    // base_ptr is the logical commit point; commit_ptr trails it by two cycles so the RAM
    // already holds the final dword when the reader is told about it.
    logic [ADDR_W-1:0] base_ptr_q, base_ptr_d;
    logic [ADDR_W-1:0] commit_stage_q, commit_ptr_q;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [LEN_W-1:0]  rx_len;
    logic              len_bad;
    logic [ADDR_W-1:0] cur_ptr;
    logic [ADDR_W-1:0] ring_used;
    logic              ring_full;
    logic              do_write, do_rollback, do_commit, do_header;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;

    assign rx_len  = rx_data[LEN_MSB:LEN_LSB];
    assign len_bad = (rx_len == '0) || (32'(rx_len) > MAX_LEN);

    // A header arriving mid-packet is placed where the rolled-back packet started.
    assign cur_ptr   = (state_q == StPayload && !rx_sop) ? wr_ptr_q : base_ptr_q;
    assign ring_used = cur_ptr - rd_addr;
    assign ring_full = (ring_used == {ADDR_W{1'b1}});

    always_comb begin
        do_write    = 1'b0;
        do_rollback = 1'b0;
        do_commit   = 1'b0;
        do_header   = 1'b0;
        drop_inc    = 2'd0;
        state_d     = state_q;
        remaining_d = remaining_q;

        if (rx_valid) begin
            unique case (state_q)
                StIdle: do_header = rx_sop;
                StDrop: begin
                    if (rx_sop) begin
                        do_header = 1'b1;
                    end else if (rx_eop) begin
                        state_d = StIdle;
                    end
                end
                StPayload: begin
                    if (rx_sop) begin
                        do_rollback = 1'b1;
                        drop_inc    = 2'd1;
                        do_header   = 1'b1;
                    end else if (ring_full) begin
                        do_rollback = 1'b1;
                        drop_inc    = 2'd1;
                        state_d     = rx_eop ? StIdle : StDrop;
                    end else if (rx_eop) begin
                        if (remaining_q == LEN_W'(1)) begin
                            do_write  = 1'b1;
                            do_commit = 1'b1;
                        end else begin
                            do_rollback = 1'b1;
                            drop_inc    = 2'd1;
                        end
                        state_d = StIdle;
                    end else if (remaining_q == LEN_W'(1)) begin
                        do_rollback = 1'b1;
                        drop_inc    = 2'd1;
                        state_d     = StDrop;
                    end else begin
                        do_write    = 1'b1;
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase

            if (do_header) begin
                if (len_bad || ring_full) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = rx_eop ? StIdle : StDrop;
                end else if (rx_eop) begin
                    do_rollback = 1'b1;
                    drop_inc    = drop_inc + 2'd1;
                    state_d     = StIdle;
                end else begin
                    do_write    = 1'b1;
                    remaining_d = rx_len;
                    state_d     = StPayload;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (do_write) begin
            wr_ptr_d = cur_ptr + ADDR_W'(1);
        end else if (do_rollback) begin
            wr_ptr_d = base_ptr_q;
        end
        base_ptr_d = do_commit ? cur_ptr + ADDR_W'(1) : base_ptr_q;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            remaining_q    <= '0;
            wr_ptr_q       <= '0;
            base_ptr_q     <= '0;
            commit_stage_q <= '0;
            commit_ptr_q   <= '0;
            drop_cnt_q     <= '0;
            RAM_wr_en      <= 1'b0;
            RAM_wr_addr    <= '0;
            RAM_wr_data    <= '0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            wr_ptr_q       <= wr_ptr_d;
            base_ptr_q     <= base_ptr_d;
            commit_stage_q <= base_ptr_q;
            commit_ptr_q   <= commit_stage_q;
            drop_cnt_q     <= drop_cnt_d;
            RAM_wr_en      <= do_write;
            if (do_write) begin
                RAM_wr_addr <= cur_ptr;
                RAM_wr_data <= rx_data;
            end
        end
    end

    assign commit_ptr = commit_ptr_q;
    assign pkt_avail  = (commit_ptr_q != rd_addr);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pcie_rx_ram_writer.sv
// Self-checking bench: packet-level reference model compared against the writer every cycle.
module tb_pcie_rx_ram_writer;

    localparam int RING = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic [10:0] rd_addr = '0;
    logic        RAM_wr_en;
    logic [10:0] RAM_wr_addr;
    logic [31:0] RAM_wr_data;
    logic [10:0] commit_ptr;
    logic        pkt_avail;
    logic [15:0] drop_cnt;

    pcie_rx_ram_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rd_addr     (rd_addr),
        .RAM_wr_en   (RAM_wr_en),
        .RAM_wr_addr (RAM_wr_addr),
        .RAM_wr_data (RAM_wr_data),
        .commit_ptr  (commit_ptr),
        .pkt_avail   (pkt_avail),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [10:0] addr;
        logic [31:0] data;
        logic [10:0] commit;
        logic [15:0] drop;
    } exp_t;

    exp_t exp_cur, exp_next;

    // Model: mode 0 = between packets, 1 = collecting payload, 2 = discarding to EOP.
    int          m_mode, m_need, m_fill;
    logic [10:0] m_base, hist_b1, hist_b2;
    logic [15:0] m_drop;
    bit          drain = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int free_slots();
        int used;
        used = (int'(m_base) + m_fill - int'(rd_addr)) & (RING - 1);
        return RING - 1 - used;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_need = 0; m_fill = 0;
        m_base = '0; hist_b1 = '0; hist_b2 = '0; m_drop = '0;
        exp_cur  = '{en: 1'b0, addr: '0, data: '0, commit: '0, drop: '0};
        exp_next = exp_cur;
    endtask

    task automatic count_drop();
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endtask

    task automatic abandon();
        m_fill = 0;
        count_drop();
        m_mode = 0;
    endtask

    task automatic emit(input logic [31:0] d);
        exp_next.en   = 1'b1;
        exp_next.addr = 11'((int'(m_base) + m_fill) & (RING - 1));
        exp_next.data = d;
        m_fill++;
    endtask

    task automatic start_hdr(input logic e, input logic [31:0] d);
        int len;
        len = int'(d[9:0]);
        if (len == 0 || len > 256 || free_slots() == 0) begin
            count_drop();
            m_mode = e ? 0 : 2;
        end else if (e) begin
            count_drop();
            m_mode = 0;
        end else begin
            emit(d);
            m_need = len;
            m_mode = 1;
        end
    endtask

    task automatic model_step(input logic v, input logic s, input logic e, input logic [31:0] d);
        exp_next.en     = 1'b0;
        exp_next.commit = hist_b2;
        if (v) begin
            if (m_mode == 1 && s) begin
                abandon();
                start_hdr(e, d);
            end else if (m_mode == 1) begin
                if (free_slots() == 0) begin
                    abandon();
                    m_mode = e ? 0 : 2;
                end else if (e) begin
                    if (m_need == 1) begin
                        emit(d);
                        m_base = 11'((int'(m_base) + m_fill) & (RING - 1));
                        m_fill = 0;
                        m_mode = 0;
                    end else begin
                        abandon();
                    end
                end else if (m_need == 1) begin
                    abandon();
                    m_mode = 2;
                end else begin
                    emit(d);
                    m_need--;
                end
            end else if (s) begin
                start_hdr(e, d);
            end else if (m_mode == 2 && e) begin
                m_mode = 0;
            end
        end
        hist_b2 = hist_b1;
        hist_b1 = m_base;
        exp_next.drop = m_drop;
    endtask

    task automatic cycle(input logic v, input logic s, input logic e, input logic [31:0] d);
        logic [10:0] room;
        @(posedge clk);
        #1;
        exp_cur = exp_next;
        if (drain && $urandom_range(0, 3) == 0) begin
            room    = exp_cur.commit - rd_addr;
            rd_addr = rd_addr + 11'($urandom_range(0, int'(room)));
        end
        rx_valid = v;
        rx_sop   = s;
        rx_eop   = e;
        rx_data  = d;
        model_step(v, s, e, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic send_pkt(input int len, input int npay);
        logic [31:0] hdr;
        hdr      = $urandom;
        hdr[9:0] = 10'(len);
        cycle(1'b1, 1'b1, npay == 0, hdr);
        for (int i = 1; i <= npay; i++) cycle(1'b1, 1'b0, i == npay, $urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"}, RAM_wr_en, 0);
        check({tag, "_wr_addr"}, RAM_wr_addr, 0);
        check({tag, "_wr_data"}, RAM_wr_data, 0);
        check({tag, "_commit"}, commit_ptr, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_avail"}, pkt_avail, 0);
    endtask

    always @(negedge clk) begin
        check("wr_en", RAM_wr_en, exp_cur.en);
        if (exp_cur.en) begin
            check("wr_addr", RAM_wr_addr, exp_cur.addr);
            check("wr_data", RAM_wr_data, exp_cur.data);
        end
        check("commit_ptr", commit_ptr, exp_cur.commit);
        check("drop_cnt", drop_cnt, exp_cur.drop);
        check("pkt_avail", pkt_avail, exp_cur.commit != rd_addr);
    end

    initial begin
        int fill, dw, len, npay, r, gap;
        model_reset();
        #1;
        check_zero_outputs("rst");
        idle(3);
        rst_n = 1'b1;

        // Good packet, LEN = 3
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0003);
        cycle(1'b1, 1'b0, 1'b0, 32'hFEAD_BEEF);
        cycle(1'b1, 1'b0, 1'b0, 32'h1111_1111);
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        idle(1);
        check("good_commit_early", commit_ptr, 0);
        idle(2);
        check("good_commit", commit_ptr, 4);
        check("good_avail", pkt_avail, 1);
        check("good_drop", drop_cnt, 0);
        check("model_base_good", m_base, 4);

        // Short packet: LEN = 4 with EOP on the 3rd payload beat
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0004);
        cycle(1'b1, 1'b0, 1'b0, 32'hA0A0_0001);
        cycle(1'b1, 1'b0, 1'b0, 32'hA0A0_0002);
        cycle(1'b1, 1'b0, 1'b1, 32'hA0A0_0003);
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0001);
        cycle(1'b1, 1'b0, 1'b1, 32'h5555_AAAA);
        check("short_next_hdr_addr", RAM_wr_addr, 4);
        check("short_drop", drop_cnt, 1);
        idle(3);
        check("short_commit", commit_ptr, 6);

        // New SOP while in payload
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0005);
        cycle(1'b1, 1'b0, 1'b0, 32'hB0B0_0001);
        cycle(1'b1, 1'b0, 1'b0, 32'hB0B0_0002);
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_0002);
        cycle(1'b1, 1'b0, 1'b0, 32'hC0C0_0001);
        check("sop_mid_hdr_en", RAM_wr_en, 1);
        check("sop_mid_hdr_addr", RAM_wr_addr, 6);
        check("sop_mid_drop", drop_cnt, 2);
        cycle(1'b1, 1'b0, 1'b1, 32'hC0C0_0002);
        idle(3);
        check("sop_mid_commit", commit_ptr, 9);

        // Fill up to 2040, then a packet that wraps the ring
        while (m_base != 11'd2040) begin
            fill = 2040 - int'(m_base);
            dw   = (fill > 257) ? 150 : fill;
            send_pkt(dw - 1, dw - 1);
        end
        idle(3);
        check("pre_wrap_commit", commit_ptr, 2040);
        rd_addr = 11'd2040;
        send_pkt(15, 15);
        idle(3);
        check("wrap_commit", commit_ptr, 8);
        check("wrap_drop", drop_cnt, 2);

        // Asynchronous reset in the middle of a payload
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_00FD);
        cycle(1'b1, 1'b0, 1'b0, $urandom);
        cycle(1'b1, 1'b0, 1'b0, $urandom);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rd_addr  = '0;
        model_reset();
        #1;
        check_zero_outputs("midrst");
        idle(2);
        rst_n = 1'b1;

        // Overflow: 2046 committed dwords with rd_addr held at 0, then LEN = 8
        cycle(1'b1, 1'b1, 1'b0, 32'h0000_00FD);
        cycle(1'b1, 1'b0, 1'b0, $urandom);
        check("post_rst_hdr_en", RAM_wr_en, 1);
        check("post_rst_hdr_addr", RAM_wr_addr, 0);
        for (int i = 2; i <= 253; i++) cycle(1'b1, 1'b0, i == 253, $urandom);
        for (int p = 0; p < 7; p++) send_pkt(255, 255);
        idle(3);
        check("ovf_fill_commit", commit_ptr, 2046);
        send_pkt(8, 8);
        idle(3);
        check("ovf_commit", commit_ptr, 2046);
        check("ovf_drop", drop_cnt, 1);
        check("model_base_ovf", m_base, 2046);

        // Randomised traffic with a lazily draining reader
        rd_addr = 11'd2046;
        drain   = 1'b1;
        for (int k = 0; k < 250; k++) begin
            len  = $urandom_range(1, 24);
            r    = $urandom_range(0, 15);
            npay = len;
            if (r == 0) begin
                len = 0; npay = 0;
            end else if (r == 1) begin
                len = 300; npay = 3;
            end else if (r == 2) begin
                npay = len + 1;
            end else if (r == 3) begin
                npay = len - 1;
            end
            if (r == 4) begin
                send_pkt(len, 0 + 1 + 0 * len);
            end else if (r == 5) begin
                cycle(1'b1, 1'b1, 1'b0, 32'(len));
                for (int i = 0; i < len / 2; i++) cycle(1'b1, 1'b0, 1'b0, $urandom);
            end else begin
                send_pkt(len, npay);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
            end
        end
        drain = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
